// File: rtl/led_pkg.sv
// led_pkg: fade-state encoding, default sizing constants and small helpers
// shared by led_fade_pwm and led_pwm_core.
package led_pkg;

  // Fade FSM state encoding; the encoding is visible on the fade_state port.
  typedef enum logic [1:0] {
    FADE_OFF  = 2'b00,
    FADE_RISE = 2'b01,
    FADE_ON   = 2'b10,
    FADE_FALL = 2'b11
  } fade_state_t;

  // Default PWM counter / brightness width.
  localparam int LED_DEFAULT_PWM_BITS = 8;

  // Default number of clocks per brightness step.
  localparam int LED_DEFAULT_STEP_DIV = 16;

  // Prescaler width; wide enough for any step divider up to 65535.
  localparam int LED_PRESC_BITS = 16;

  // True for the two states in which the level ramps.
  function automatic logic is_fading(input fade_state_t s);
    return (s == FADE_RISE) || (s == FADE_FALL);
  endfunction

  // True when a state change is the natural end of a ramp (RISE->ON, FALL->OFF).
  function automatic logic is_fade_end(input fade_state_t from_s, input fade_state_t to_s);
    return ((from_s == FADE_RISE) && (to_s == FADE_ON)) ||
           ((from_s == FADE_FALL) && (to_s == FADE_OFF));
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// led_pwm_core: free-running PWM counter, brightness-to-duty mapping and the
// registered comparator that drives the LED pad.
// Build option: define LED_FADE_GAMMA_EN to map duty = (level*level) >> PWM_BITS
// (perceptual square-law curve); otherwise duty equals level.
module led_pwm_core
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_DEFAULT_PWM_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] level,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] count_r;
  logic [PWM_BITS-1:0] duty_s;
  logic                pwm_r;

`ifdef LED_FADE_GAMMA_EN
  // Square-law gamma: full-width product, keep the upper half.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] wide;
    logic [2*PWM_BITS-1:0] sq;
    wide = {{PWM_BITS{1'b0}}, lvl};
    sq   = wide * wide;
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  assign duty_s = gamma_map(level);
`else
  assign duty_s = level;
`endif

  // PWM period counter: free-runs and wraps naturally, independent of the fade FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + PWM_BITS'(1);
    end
  end

  // Comparator register: high while the period counter is below the duty value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= (count_r < duty_s);
    end
  end

  assign pwm_out = pwm_r;

endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: fades an LED between dark and full brightness on request.
// A four-state FSM (OFF/RISE/ON/FALL) ramps the brightness level by one every
// STEP_DIV clocks; led_pwm_core turns the level into a registered PWM drive.
// Build option: LED_FADE_GAMMA_EN selects the gamma duty mapping inside
// led_pwm_core; FSM, level and timing are identical in both builds.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_DEFAULT_PWM_BITS,
  parameter int STEP_DIV = LED_DEFAULT_STEP_DIV
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                led_req,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          fade_state,
  output logic                fade_done
);

  localparam logic [PWM_BITS-1:0]       LEVEL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]       LEVEL_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0]       LEVEL_ONE  = PWM_BITS'(1);
  localparam logic [LED_PRESC_BITS-1:0] PRESC_LAST = LED_PRESC_BITS'(STEP_DIV - 1);
  localparam logic [LED_PRESC_BITS-1:0] PRESC_ZERO = {LED_PRESC_BITS{1'b0}};
  localparam logic [LED_PRESC_BITS-1:0] PRESC_ONE  = LED_PRESC_BITS'(1);

  fade_state_t               state_r;
  fade_state_t               state_s;
  logic [PWM_BITS-1:0]       level_r;
  logic [PWM_BITS-1:0]       level_s;
  logic [PWM_BITS-1:0]       stepped_level_s;
  logic [LED_PRESC_BITS-1:0] presc_r;
  logic [LED_PRESC_BITS-1:0] presc_s;
  logic                      done_r;
  logic                      done_s;
  logic                      step_due_s;

  // A step is due on the STEP_DIV-th clock since the prescaler last cleared.
  assign step_due_s = (presc_r == PRESC_LAST);

  // Step datapath: the level a ramping state holds after this edge, saturating
  // at the ends so the level can never wrap.
  always_comb begin
    stepped_level_s = level_r;
    if (step_due_s) begin
      case (state_r)
        FADE_RISE: begin
          if (level_r != LEVEL_MAX) begin
            stepped_level_s = level_r + LEVEL_ONE;
          end else begin
            stepped_level_s = level_r;
          end
        end
        FADE_FALL: begin
          if (level_r != LEVEL_ZERO) begin
            stepped_level_s = level_r - LEVEL_ONE;
          end else begin
            stepped_level_s = level_r;
          end
        end
        default: begin
          stepped_level_s = level_r;
        end
      endcase
    end else begin
      stepped_level_s = level_r;
    end
  end

  // FSM state register: asynchronous reset returns the block to OFF.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FADE_OFF;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: enable low wins; a change of led_req wins over ramp completion.
  always_comb begin
    state_s = state_r;
    if (!enable) begin
      state_s = FADE_OFF;
    end else begin
      case (state_r)
        FADE_OFF: begin
          if (led_req) begin
            state_s = FADE_RISE;
          end else begin
            state_s = FADE_OFF;
          end
        end
        FADE_RISE: begin
          if (!led_req) begin
            state_s = FADE_FALL;
          end else if (stepped_level_s == LEVEL_MAX) begin
            state_s = FADE_ON;
          end else begin
            state_s = FADE_RISE;
          end
        end
        FADE_ON: begin
          if (!led_req) begin
            state_s = FADE_FALL;
          end else begin
            state_s = FADE_ON;
          end
        end
        FADE_FALL: begin
          if (led_req) begin
            state_s = FADE_RISE;
          end else if (stepped_level_s == LEVEL_ZERO) begin
            state_s = FADE_OFF;
          end else begin
            state_s = FADE_FALL;
          end
        end
        default: begin
          state_s = FADE_OFF;
        end
      endcase
    end
  end

  // FSM outputs: next level, prescaler and completion pulse for the registers.
  always_comb begin
    level_s = level_r;
    presc_s = presc_r;
    done_s  = 1'b0;
    if (!enable) begin
      level_s = LEVEL_ZERO;
      presc_s = PRESC_ZERO;
      done_s  = 1'b0;
    end else begin
      case (state_r)
        FADE_RISE, FADE_FALL: begin
          level_s = stepped_level_s;
        end
        FADE_ON: begin
          level_s = level_r;
        end
        default: begin
          level_s = LEVEL_ZERO;
        end
      endcase
      if (state_s != state_r) begin
        presc_s = PRESC_ZERO;
        done_s  = is_fade_end(state_r, state_s);
      end else if (!is_fading(state_r)) begin
        presc_s = PRESC_ZERO;
        done_s  = 1'b0;
      end else if (step_due_s) begin
        presc_s = PRESC_ZERO;
        done_s  = 1'b0;
      end else begin
        presc_s = presc_r + PRESC_ONE;
        done_s  = 1'b0;
      end
    end
  end

  // Datapath registers: level, step prescaler and fade_done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= LEVEL_ZERO;
      presc_r <= PRESC_ZERO;
      done_r  <= 1'b0;
    end else begin
      level_r <= level_s;
      presc_r <= presc_s;
      done_r  <= done_s;
    end
  end

  led_pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_core (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (level_r),
    .pwm_out (pwm_out)
  );

  assign level      = level_r;
  assign fade_state = state_r;
  assign fade_done  = done_r;

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: scoreboard bench for led_fade_pwm. Two instances share the
// clock, reset and enable: dut0 (STEP_DIV=2) and dut1 (STEP_DIV=1, own led_req).
// A reference model computes the expected outputs per edge and queues them; a
// negedge monitor pops and compares. Directed checks cover the fade corner cases.
module tb_led_fade_pwm;

  localparam int MAXL   = 255;
  localparam int S_OFF  = 0;
  localparam int S_RISE = 1;
  localparam int S_ON   = 2;
  localparam int S_FALL = 3;
`ifdef LED_FADE_GAMMA_EN
  localparam int EXP_HI64 = 16;
`else
  localparam int EXP_HI64 = 64;
`endif

  typedef struct {
    int k;
    int lvl;
    int st;
    int done;
    int pwm;
  } exp_t;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       enable   = 1'b0;
  logic       led_req0 = 1'b0;
  logic       led_req1 = 1'b0;
  logic       pwm0, pwm1, done0, done1;
  logic [7:0] level0, level1;
  logic [1:0] st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];

  // reference model state, one slot per instance
  int div_k[2] = '{2, 1};
  int m_st[2];
  int m_lvl[2];
  int m_since[2];
  int m_done[2];
  int m_pwm[2];
  int m_cnt[2];

  led_fade_pwm #(.PWM_BITS(8), .STEP_DIV(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .led_req(led_req0),
    .pwm_out(pwm0), .level(level0), .fade_state(st0), .fade_done(done0)
  );

  led_fade_pwm #(.PWM_BITS(8), .STEP_DIV(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .led_req(led_req1),
    .pwm_out(pwm1), .level(level1), .fade_state(st1), .fade_done(done1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> 8;
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_OFF; m_lvl[k] = 0; m_since[k] = 0;
      m_done[k] = 0; m_pwm[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // One clock of behaviour: pwm from the level held before the edge, then the
  // fade rules. A step lands on every div-th clock since the phase began.
  task automatic model_step(input int k, input logic en, input logic req);
    m_pwm[k]  = (m_cnt[k] < duty_of(m_lvl[k])) ? 1 : 0;
    m_cnt[k]  = (m_cnt[k] + 1) % 256;
    m_done[k] = 0;
    if (!en) begin
      m_st[k] = S_OFF; m_lvl[k] = 0; m_since[k] = 0;
    end else if (m_st[k] == S_OFF) begin
      if (req) begin m_st[k] = S_RISE; m_since[k] = 0; end
    end else if (m_st[k] == S_ON) begin
      if (!req) begin m_st[k] = S_FALL; m_since[k] = 0; end
    end else if (m_st[k] == S_RISE) begin
      m_since[k]++;
      if ((m_since[k] % div_k[k]) == 0 && m_lvl[k] < MAXL) m_lvl[k]++;
      if (!req) begin m_st[k] = S_FALL; m_since[k] = 0; end
      else if (m_lvl[k] == MAXL) begin m_st[k] = S_ON; m_done[k] = 1; m_since[k] = 0; end
    end else begin
      m_since[k]++;
      if ((m_since[k] % div_k[k]) == 0 && m_lvl[k] > 0) m_lvl[k]--;
      if (req) begin m_st[k] = S_RISE; m_since[k] = 0; end
      else if (m_lvl[k] == 0) begin m_st[k] = S_OFF; m_done[k] = 1; m_since[k] = 0; end
    end
  endtask

  // Drive inputs, let the DUT take one edge, push the model's expectation.
  task automatic tick(input logic en, input logic r0, input logic r1);
    exp_t e;
    enable = en; led_req0 = r0; led_req1 = r1;
    @(posedge clock);
    model_step(0, en, r0);
    model_step(1, en, r1);
    for (int k = 0; k < 2; k++) begin
      e.k = k; e.lvl = m_lvl[k]; e.st = m_st[k]; e.done = m_done[k]; e.pwm = m_pwm[k];
      sb_q.push_back(e);
    end
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.k == 0) begin
        check("sb level0", int'(level0), e.lvl);
        check("sb state0", int'(st0), e.st);
        check("sb done0", int'(done0), e.done);
        check("sb pwm0", int'(pwm0), e.pwm);
      end else begin
        check("sb level1", int'(level1), e.lvl);
        check("sb state1", int'(st1), e.st);
        check("sb done1", int'(done1), e.done);
        check("sb pwm1", int'(pwm1), e.pwm);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   hi;
    int   prev;
    int   d;
    logic r;
    logic r0;
    logic r1;
    logic en;

    model_reset();
    #12;
    check("reset level", int'(level0), 0);
    check("reset state", int'(st0), S_OFF);
    check("reset pwm", int'(pwm0), 0);
    check("reset done", int'(done0), 0);
    @(negedge clock); #1;
    reset_n = 1'b1;

    // full rise: RISE next edge, ON after 255*2 clocks, one-clock done pulse
    tick(1'b1, 1'b1, 1'b1);
    check("rise entered", int'(st0), S_RISE);
    n = 0;
    while (st0 != 2'b10 && n < 600) begin tick(1'b1, 1'b1, 1'b1); n++; end
    check("rise clocks", n, 510);
    check("rise done", int'(done0), 1);
    check("rise level", int'(level0), 255);
    tick(1'b1, 1'b1, 1'b1);
    check("done width", int'(done0), 0);

    // enable dropped while ON: dark at the next edge without a done pulse
    tick(1'b0, 1'b1, 1'b1);
    check("en drop level", int'(level0), 0);
    check("en drop state", int'(st0), S_OFF);
    check("en drop done", int'(done0), 0);

    // hold level 64 by toggling led_req every clock, count pwm highs
    n = 0;
    while (m_lvl[0] != 64 && n < 400) begin tick(1'b1, 1'b1, 1'b1); n++; end
    r = 1'b1;
    hi = 0;
    for (int i = 0; i < 258; i++) begin
      r = ~r;
      tick(1'b1, r, r);
      if (i >= 2 && pwm0 === 1'b1) hi++;
    end
    check("hold level64", int'(level0), 64);
    check("pwm highs at 64", hi, EXP_HI64);

    // drop led_req at level 100 while rising
    n = 0;
    while (m_lvl[0] != 100 && n < 400) begin tick(1'b1, 1'b1, 1'b1); n++; end
    tick(1'b1, 1'b0, 1'b0);
    check("drop state", int'(st0), S_FALL);
    check("drop level", int'(level0), 100);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("drop first step", int'(level0), 99);
    n = 2;
    while (st0 != 2'b00 && n < 400) begin tick(1'b1, 1'b0, 1'b0); n++; end
    check("fall clocks", n, 200);
    check("fall done", int'(done0), 1);

    // asynchronous reset mid-rise at level 40
    n = 0;
    while (m_lvl[0] != 40 && n < 200) begin tick(1'b1, 1'b1, 1'b1); n++; end
    check("pre reset level", int'(level0), 40);
    @(negedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("async level", int'(level0), 0);
    check("async state", int'(st0), S_OFF);
    check("async pwm", int'(pwm0), 0);
    check("async done", int'(done0), 0);
    check("async level1", int'(level1), 0);
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    check("restart state", int'(st0), S_OFF);

    // STEP_DIV=1 instance: toggle led_req every clock from level 4
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
    prev = int'(level1);
    r = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = ~r;
      tick(1'b1, 1'b0, r);
      d = int'(level1) - prev;
      if (d < 0) d = -d;
      check("osc delta", d, 1);
      check("osc done", int'(done1), 0);
      prev = int'(level1);
    end

    // same toggling from dark: oscillates 0/1, never wraps, never completes
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    prev = int'(level1);
    r = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = ~r;
      tick(1'b1, 1'b0, r);
      d = int'(level1) - prev;
      if (d < 0) d = -d;
      check("osc0 delta", d, 1);
      check("osc0 no wrap", (level1 <= 8'd1) ? 1 : 0, 1);
      check("osc0 done", int'(done1), 0);
      prev = int'(level1);
    end

    // randomized phase checked through the scoreboard
    r0 = 1'b1;
    r1 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 299) == 0) r0 = ~r0;
      if ($urandom_range(0, 99) == 0) r1 = ~r1;
      if ($urandom_range(0, 199) == 0) r1 = ~r1;
      tick(en, r0, r1);
    end

    @(negedge clock); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
LED_FADE_PWM -- requirements
Module: led_fade_pwm

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, giving the PWM counter and brightness-level width.
REQ-002 The block SHALL have parameter STEP_DIV, default 16, giving clocks per brightness step (legal range 1..65535).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: 0 forces the block dark.
REQ-006 The block SHALL have port led_req, input, 1 bit: 1 requests lit, 0 requests dark; it is driven by the upstream blink FSM.
REQ-007 The block SHALL have port pwm_out, output, 1 bit: the registered PWM drive to the LED pad.
REQ-008 The block SHALL have port level, output, PWM_BITS bits: the current brightness level.
REQ-009 The block SHALL have port fade_state, output, 2 bits: the current FSM state encoding.
REQ-010 The block SHALL have port fade_done, output, 1 bit: a one-clock pulse when a fade completes.

Function
REQ-011 PWM counter SHALL free-run 0..2^PWM_BITS-1, wrap to 0, and run regardless of state.
REQ-012 pwm_out SHALL be registered as (counter < duty) with one clock latency; level 0 -> constant 0; level MAX (2^PWM_BITS-1) -> high MAX of every 2^PWM_BITS clocks.
REQ-013 FSM states SHALL be OFF=2'b00, RISE=2'b01, ON=2'b10, FALL=2'b11.
REQ-014 OFF: level=0; led_req=1 and enable=1 -> RISE.
REQ-015 RISE: level SHALL increment by 1 every STEP_DIV clocks; at level==MAX -> ON with fade_done pulse that cycle; led_req=0 -> FALL, continuing from the current level with no jump.
REQ-016 ON: level SHALL hold at MAX; led_req=0 -> FALL.
REQ-017 FALL: level SHALL decrement by 1 every STEP_DIV clocks; at level==0 -> OFF with fade_done pulse; led_req=1 -> RISE from the current level.
REQ-018 The step prescaler SHALL clear on every state transition, so the first step after a transition occurs STEP_DIV clocks later.
REQ-019 led_req SHALL take effect on the FSM at the first clock edge where it is sampled changed; there is no input synchroniser, because upstream is same-clock.
REQ-020 enable=0 SHALL force state OFF, level 0 and prescaler 0 at the next edge, overriding led_req and any fade in progress; fade_done SHALL NOT pulse.
REQ-021 level SHALL never wrap: there is no increment above MAX and no decrement below 0.
REQ-022 A full fade SHALL take exactly MAX*STEP_DIV clocks from entering RISE (or FALL) to reaching ON (or OFF).

Reset
REQ-023 reset_n=0 SHALL asynchronously force state OFF, level 0, PWM counter 0, prescaler 0, pwm_out 0 and fade_done 0.
REQ-024 Deassertion of reset mid-fade SHALL restart the block from OFF; no prior fade state is retained.

Configuration
REQ-025 With macro LED_FADE_GAMMA_EN defined, duty SHALL be (level*level)>>PWM_BITS, a 2*PWM_BITS-bit product truncated; without it, duty SHALL equal level.
REQ-026 The macro SHALL affect only duty; FSM, level and timing SHALL be identical in both builds.

Structure
REQ-027 Package led_pkg SHALL hold the fade-state encodings and default PWM_BITS/STEP_DIV constants.
REQ-028 One sub-module, led_pwm_core, SHALL contain the PWM counter, the optional gamma mapping and the pwm_out comparator register.

Verification (PWM_BITS=8, STEP_DIV=2 unless stated)
REQ-029 The bench SHALL cover: reset_n low mid-RISE at level 40 -> level 0, fade_state 00 and pwm_out 0 immediately, without waiting for a clock.
REQ-030 The bench SHALL cover: enable=1 with led_req held 1 -> fade_state 01, then ON after 510 clocks, fade_done exactly 1 clock, level 255.
REQ-031 The bench SHALL cover: led_req dropped at level 100 during RISE -> FALL next edge, level 99 two clocks later, and OFF after 200 clocks total.
REQ-032 The bench SHALL cover: enable dropped during ON -> level 0 and state OFF next edge, no fade_done pulse.
REQ-033 The bench SHALL cover: level held at 64 over 256 clocks -> 64 pwm_out high cycles in the linear build, 16 in the LED_FADE_GAMMA_EN build.
REQ-034 The bench SHALL cover: STEP_DIV=1 with led_req toggled every clock -> level oscillates by +/-1 with no wrap, and no fade_done pulse.
